// File: rtl/mem_bus_arbiter.sv
// Arbiter sharing one single-port memory bus between fetch and data access.
// Data access wins ties; a hung slave is released after TIMEOUT bus cycles.
module mem_bus_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_data_o,
  output logic        if_ack_o,
  output logic        stallreq_if_o,
  input  logic        flush_i,
  input  logic        dm_req_i,
  input  logic        dm_we_i,
  input  logic [3:0]  dm_sel_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_wdata_i,
  output logic [31:0] dm_rdata_o,
  output logic        dm_ack_o,
  output logic        stallreq_dm_o,
  output logic        bus_cyc_o,
  output logic        bus_stb_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,
  output logic        bus_err_o
);

  typedef enum logic [2:0] {
    IDLE,
    DM_BUS,
    IF_BUS,
    DM_DONE,
    IF_DONE
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cyc_q, cyc_d;
  logic              we_q, we_d;
  logic [3:0]        sel_q, sel_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       if_data_q, if_data_d;
  logic [31:0]       dm_rdata_q, dm_rdata_d;
  logic              if_ack_q, if_ack_d;
  logic              dm_ack_q, dm_ack_d;
  logic              err_q, err_d;
  logic              timeout;
  logic [31:0]       cap_data;

  assign timeout  = (cnt_q == CNT_LAST);
  // A timed-out access completes with zero data.
  assign cap_data = bus_ack_i ? bus_rdata_i : 32'h0;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cyc_d      = cyc_q;
    we_d       = we_q;
    sel_d      = sel_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_data_d  = if_data_q;
    dm_rdata_d = dm_rdata_q;
    if_ack_d   = 1'b0;
    dm_ack_d   = 1'b0;
    err_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (dm_req_i) begin
          state_d = DM_BUS;
          cnt_d   = '0;
          cyc_d   = 1'b1;
          we_d    = dm_we_i;
          sel_d   = dm_sel_i;
          addr_d  = dm_addr_i;
          wdata_d = dm_wdata_i;
        end else if (if_req_i && !flush_i) begin
          state_d = IF_BUS;
          cnt_d   = '0;
          cyc_d   = 1'b1;
          we_d    = 1'b0;
          sel_d   = 4'hF;
          addr_d  = if_addr_i;
          wdata_d = 32'h0;
        end
      end
      DM_BUS: begin
        cnt_d = cnt_q + 1'b1;
        if (bus_ack_i || timeout) begin
          state_d  = DM_DONE;
          cyc_d    = 1'b0;
          we_d     = 1'b0;
          dm_ack_d = 1'b1;
          err_d    = !bus_ack_i;
          if (!we_q) dm_rdata_d = cap_data;
        end
      end
      IF_BUS: begin
        cnt_d = cnt_q + 1'b1;
        // Flush outranks a same-cycle slave ack.
        if (flush_i) begin
          state_d = IDLE;
          cyc_d   = 1'b0;
          we_d    = 1'b0;
        end else if (bus_ack_i || timeout) begin
          state_d   = IF_DONE;
          cyc_d     = 1'b0;
          we_d      = 1'b0;
          if_ack_d  = 1'b1;
          err_d     = !bus_ack_i;
          if_data_d = cap_data;
        end
      end
      DM_DONE: state_d = IDLE;
      IF_DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      sel_q      <= 4'h0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      if_data_q  <= 32'h0;
      dm_rdata_q <= 32'h0;
      if_ack_q   <= 1'b0;
      dm_ack_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cyc_q      <= cyc_d;
      we_q       <= we_d;
      sel_q      <= sel_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_data_q  <= if_data_d;
      dm_rdata_q <= dm_rdata_d;
      if_ack_q   <= if_ack_d;
      dm_ack_q   <= dm_ack_d;
      err_q      <= err_d;
    end
  end

  assign if_data_o     = if_data_q;
  assign if_ack_o      = if_ack_q;
  assign dm_rdata_o    = dm_rdata_q;
  assign dm_ack_o      = dm_ack_q;
  assign bus_cyc_o     = cyc_q;
  assign bus_stb_o     = cyc_q;
  assign bus_we_o      = we_q;
  assign bus_sel_o     = sel_q;
  assign bus_addr_o    = addr_q;
  assign bus_wdata_o   = wdata_q;
  assign bus_err_o     = err_q;
  assign stallreq_if_o = if_req_i & ~if_ack_q;
  assign stallreq_dm_o = dm_req_i & ~dm_ack_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus random traffic
// compared every cycle against a transaction-level reference model.
module tb_mem_bus_arbiter;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i, flush_i;
  logic [31:0] if_addr_i, if_data_o;
  logic        if_ack_o, stallreq_if_o;
  logic        dm_req_i, dm_we_i;
  logic [3:0]  dm_sel_i;
  logic [31:0] dm_addr_i, dm_wdata_i, dm_rdata_o;
  logic        dm_ack_o, stallreq_dm_o;
  logic        bus_cyc_o, bus_stb_o, bus_we_o, bus_err_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_addr_o, bus_wdata_o, bus_rdata_i;
  logic        bus_ack_i;

  mem_bus_arbiter #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i),
    .if_data_o(if_data_o), .if_ack_o(if_ack_o),
    .stallreq_if_o(stallreq_if_o), .flush_i(flush_i),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i),
    .dm_sel_i(dm_sel_i), .dm_addr_i(dm_addr_i),
    .dm_wdata_i(dm_wdata_i), .dm_rdata_o(dm_rdata_o),
    .dm_ack_o(dm_ack_o), .stallreq_dm_o(stallreq_dm_o),
    .bus_cyc_o(bus_cyc_o), .bus_stb_o(bus_stb_o),
    .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
    .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i),
    .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: who owns the bus, how long it has held it,
  // and whether the completion handshake cycle is in progress.
  int          m_owner = 0;
  int          m_used = 0;
  bit          m_done = 0;
  logic        e_cyc = 0, e_we = 0, e_err = 0;
  logic        e_if_ack = 0, e_dm_ack = 0;
  logic [3:0]  e_sel = 0;
  logic [31:0] e_addr = 0, e_wdata = 0;
  logic [31:0] e_if_data = 0, e_dm_rdata = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit to;
    logic [31:0] d;
    e_if_ack = 0;
    e_dm_ack = 0;
    e_err = 0;
    if (rst) begin
      m_owner = 0; m_used = 0; m_done = 0;
      e_cyc = 0; e_we = 0; e_sel = 0; e_addr = 0; e_wdata = 0;
      e_if_data = 0; e_dm_rdata = 0;
    end else if (m_done) begin
      m_done = 0;
      m_owner = 0;
    end else if (m_owner == 0) begin
      if (dm_req_i) begin
        m_owner = 1; m_used = 0;
        e_cyc = 1; e_we = dm_we_i; e_sel = dm_sel_i;
        e_addr = dm_addr_i; e_wdata = dm_wdata_i;
      end else if (if_req_i && !flush_i) begin
        m_owner = 2; m_used = 0;
        e_cyc = 1; e_we = 0; e_sel = 4'hF;
        e_addr = if_addr_i; e_wdata = 0;
      end
    end else begin
      m_used++;
      if (m_owner == 2 && flush_i) begin
        m_owner = 0; e_cyc = 0; e_we = 0;
      end else if (bus_ack_i || m_used == TO) begin
        to = !bus_ack_i;
        d = to ? 32'h0 : bus_rdata_i;
        if (m_owner == 1) begin
          e_dm_ack = 1;
          if (!e_we) e_dm_rdata = d;
        end else begin
          e_if_ack = 1;
          e_if_data = d;
        end
        e_err = to;
        e_cyc = 0; e_we = 0;
        m_done = 1;
      end
    end
  endtask

  task automatic compare();
    chk("if_ack", if_ack_o, e_if_ack);
    chk("dm_ack", dm_ack_o, e_dm_ack);
    chk("if_data", if_data_o, e_if_data);
    chk("dm_rdata", dm_rdata_o, e_dm_rdata);
    chk("cyc", bus_cyc_o, e_cyc);
    chk("stb", bus_stb_o, e_cyc);
    chk("we", bus_we_o, e_we);
    chk("err", bus_err_o, e_err);
    if (e_cyc) begin
      chk("sel", bus_sel_o, e_sel);
      chk("addr", bus_addr_o, e_addr);
      chk("wdata", bus_wdata_o, e_wdata);
    end
  endtask

  // Inputs for this cycle are already applied by the caller.
  task automatic tick();
    #1;
    chk("stall_if", stallreq_if_o, if_req_i & ~e_if_ack);
    chk("stall_dm", stallreq_dm_o, dm_req_i & ~e_dm_ack);
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  task automatic idle_inputs();
    if_req_i = 0; flush_i = 0; dm_req_i = 0;
    bus_ack_i = 0; bus_rdata_i = 0;
  endtask

  int  cnt;
  bit  seen;
  bit  dm_rel, if_rel;

  initial begin
    rst = 1;
    if_addr_i = 0; dm_we_i = 0; dm_sel_i = 0;
    dm_addr_i = 0; dm_wdata_i = 0;
    idle_inputs();
    tick();
    tick();
    chk("rst_cyc", bus_cyc_o, 0);
    chk("rst_addr", bus_addr_o, 0);
    rst = 0;
    tick();

    // 1: lone fetch, slave acks in first bus cycle
    if_req_i = 1; if_addr_i = 32'h40;
    tick();
    chk("t1_cyc", bus_cyc_o, 1);
    chk("t1_addr", bus_addr_o, 32'h40);
    chk("t1_sel", bus_sel_o, 4'hF);
    bus_ack_i = 1; bus_rdata_i = 32'h3401_1100;
    tick();
    chk("t1_ack", if_ack_o, 1);
    chk("t1_data", if_data_o, 32'h3401_1100);
    chk("t1_stall", stallreq_if_o, 0);
    bus_ack_i = 0;
    tick();
    idle_inputs();
    tick();

    // 2: simultaneous requests, data first
    if_req_i = 1; if_addr_i = 32'h44;
    dm_req_i = 1; dm_we_i = 0; dm_sel_i = 4'hF;
    dm_addr_i = 32'h100; dm_wdata_i = 32'h0;
    tick();
    chk("t2_addr", bus_addr_o, 32'h100);
    chk("t2_stall", stallreq_if_o, 1);
    bus_ack_i = 1; bus_rdata_i = 32'hDEAD_BEEF;
    tick();
    chk("t2_dmack", dm_ack_o, 1);
    chk("t2_rdata", dm_rdata_o, 32'hDEAD_BEEF);
    chk("t2_noif", if_ack_o, 0);
    bus_ack_i = 0;
    tick();
    chk("t2_gap", bus_cyc_o, 0);
    dm_req_i = 0;
    tick();
    chk("t2_ifaddr", bus_addr_o, 32'h44);
    bus_ack_i = 1; bus_rdata_i = 32'h13;
    tick();
    chk("t2_ifack", if_ack_o, 1);
    bus_ack_i = 0;
    tick();
    idle_inputs();
    tick();

    // 3: write with three wait states
    dm_req_i = 1; dm_we_i = 1; dm_sel_i = 4'b0011;
    dm_addr_i = 32'h200; dm_wdata_i = 32'h0000_ABCD;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      bus_ack_i = (i == 4); bus_rdata_i = 32'h1234_5678;
      tick();
      if (bus_we_o && bus_sel_o == 4'b0011) cnt++;
    end
    chk("t3_we_cycles", cnt, 4);
    chk("t3_ack", dm_ack_o, 1);
    chk("t3_rdata", dm_rdata_o, 32'hDEAD_BEEF);
    bus_ack_i = 0;
    tick();
    idle_inputs();
    tick();

    // 4: read timeout, slave silent
    dm_req_i = 1; dm_we_i = 0; dm_sel_i = 4'hF;
    dm_addr_i = 32'h300;
    cnt = 0; seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (bus_cyc_o) cnt++;
      if (dm_ack_o) begin
        seen = 1;
        chk("t4_err", bus_err_o, 1);
        chk("t4_rdata", dm_rdata_o, 0);
      end
    end
    chk("t4_ack_seen", seen, 1);
    chk("t4_cyc_cycles", cnt, TO);
    tick();
    idle_inputs();
    tick();

    // 5: flush during fetch wait state
    if_req_i = 1; if_addr_i = 32'h80;
    tick();
    flush_i = 1;
    tick();
    chk("t5_drop", bus_cyc_o, 0);
    chk("t5_noack", if_ack_o, 0);
    flush_i = 0; bus_ack_i = 1; bus_rdata_i = 32'h55;
    tick();
    chk("t5_restart", bus_cyc_o, 1);
    chk("t5_noack2", if_ack_o, 0);
    chk("t5_keep", if_data_o, 32'h13);
    bus_rdata_i = 32'h66;
    tick();
    chk("t5_ack", if_ack_o, 1);
    chk("t5_data", if_data_o, 32'h66);
    bus_ack_i = 0;
    tick();
    idle_inputs();
    tick();

    // 6: reset during data bus cycle
    dm_req_i = 1; dm_we_i = 1; dm_sel_i = 4'hC;
    dm_addr_i = 32'h400; dm_wdata_i = 32'h77;
    tick();
    rst = 1;
    tick();
    chk("t6_cyc", bus_cyc_o, 0);
    chk("t6_addr", bus_addr_o, 0);
    chk("t6_sel", bus_sel_o, 0);
    idle_inputs();
    rst = 0; bus_ack_i = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t6_stale", dm_ack_o, 0);
    end
    idle_inputs();
    tick();

    // Random traffic
    dm_rel = 0; if_rel = 0;
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      if (rst) begin
        dm_req_i = 0; if_req_i = 0;
        dm_rel = 0; if_rel = 0;
      end else begin
        if (dm_rel) begin dm_req_i = 0; dm_rel = 0; end
        if (!dm_req_i && $urandom_range(0, 3) == 0) begin
          dm_req_i = 1;
          dm_we_i = $urandom_range(0, 1) == 1;
          dm_sel_i = 4'($urandom);
          dm_addr_i = $urandom;
          dm_wdata_i = $urandom;
        end
        dm_rel = dm_req_i && e_dm_ack;
        if (if_rel) begin if_req_i = 0; if_rel = 0; end
        if (!if_req_i && $urandom_range(0, 2) == 0) begin
          if_req_i = 1;
          if_addr_i = $urandom;
        end
        if_rel = if_req_i && e_if_ack;
      end
      flush_i = ($urandom_range(0, 15) == 0);
      if (flush_i && if_req_i && !e_if_ack) if_addr_i = $urandom;
      bus_rdata_i = $urandom;
      bus_ack_i = ($urandom_range(0, 2) == 0);
      if (e_cyc && e_we && m_used == TO - 1) bus_ack_i = 1;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
